// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port synchronous memory shared by fetch (I)
// and load/store (D). Data wins over fetch; a starvation counter lets fetch in.
module mem_port_arbiter #(
    parameter int ADDRWIDTH    = 18,
    parameter int DATAWIDTH    = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_signal,
    input  logic                 if_req,
    input  logic [ADDRWIDTH-1:0] if_addr,
    output logic                 if_ack,
    output logic [DATAWIDTH-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [ADDRWIDTH-1:0] d_addr,
    input  logic [DATAWIDTH-1:0] d_wdata,
    output logic                 d_ack,
    output logic [DATAWIDTH-1:0] d_rdata,
    output logic                 mem_write,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_in,
    input  logic [DATAWIDTH-1:0] mem_out,
    output logic                 stall_fetch,
    output logic                 stall_mem,
    output logic                 busy
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   wr_q, wr_d;
    logic                   if_ack_q, if_ack_d;
    logic                   d_ack_q, d_ack_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDRWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATAWIDTH-1:0]   mem_in_q, mem_in_d;
    logic [DATAWIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATAWIDTH-1:0]   d_rdata_q, d_rdata_d;

    logic done, arb, i_ok, d_ok, starve_hit, gnt_i, gnt_d;

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_signal) begin
        if (!rst_signal) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            wr_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_in_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            wr_q        <= wr_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_in_q    <= mem_in_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Completion, arbitration (completing requester excluded) and grant
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        wr_d        = wr_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_in_d    = mem_in_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        done = (state_q != IDLE) && (cnt_q == CW'(MEM_LATENCY));

        if (state_q != IDLE && !done) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (done) begin
            state_d = IDLE;
            if (state_q == BUSY_I) begin
                if_ack_d   = 1'b1;
                if_rdata_d = mem_out;
            end else begin
                d_ack_d = 1'b1;
                if (!wr_q) begin
                    d_rdata_d = mem_out;
                end
            end
        end

        arb        = (state_q == IDLE) || done;
        i_ok       = if_req && !(done && state_q == BUSY_I);
        d_ok       = d_req && !(done && state_q == BUSY_D);
        starve_hit = (starve_q == SW'(STARVE_LIMIT));
        gnt_d      = arb && d_ok && !(i_ok && starve_hit);
        gnt_i      = arb && i_ok && !gnt_d;

        if (gnt_d) begin
            state_d     = BUSY_D;
            cnt_d       = '0;
            wr_d        = d_write;
            mem_write_d = d_write;
            mem_addr_d  = d_addr;
            mem_in_d    = d_wdata;
        end else if (gnt_i) begin
            state_d    = BUSY_I;
            cnt_d      = '0;
            wr_d       = 1'b0;
            mem_addr_d = if_addr;
        end

        if (!if_req || gnt_i) begin
            starve_d = '0;
        end else if (gnt_d && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_in      = mem_in_q;
    assign stall_fetch = if_req & ~if_ack_q;
    assign stall_mem   = d_req & ~d_ack_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random
// traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int L = 1;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst_signal;
    logic        if_req, d_req, d_write;
    logic [17:0] if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_ack, d_ack, mem_write, stall_fetch, stall_mem, busy;
    logic [31:0] if_rdata, d_rdata, mem_in, mem_out;
    logic [17:0] mem_addr;

    logic        if_req3, d_req3, d_write3;
    logic [17:0] if_addr3, d_addr3;
    logic [31:0] d_wdata3;
    logic        if_ack3, d_ack3, mem_write3, stall_fetch3, stall_mem3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_in3, mem_out3;
    logic [17:0] mem_addr3;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .rst_signal(rst_signal),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(LIM)) u_dut3 (
        .clk(clk), .rst_signal(rst_signal),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_write(d_write3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3), .mem_write(mem_write3),
        .mem_addr(mem_addr3), .mem_in(mem_in3), .mem_out(mem_out3),
        .stall_fetch(stall_fetch3), .stall_mem(stall_mem3), .busy(busy3)
    );

    function automatic logic [31:0] base(input logic [7:0] a);
        if (a == 8'h10) return 32'h2402000A;
        if (a == 8'h40) return 32'h0000CAFE;
        return {24'h0, a} * 32'h9E3779B1;
    endfunction

    // memory for the latency-1 instance: one registered read stage
    logic [31:0] tmem [256];
    bit          tval [256];
    always @(posedge clk) begin
        if (mem_write) begin
            tmem[mem_addr[7:0]] <= mem_in;
            tval[mem_addr[7:0]] <= 1'b1;
        end
        mem_out <= tval[mem_addr[7:0]] ? tmem[mem_addr[7:0]] : base(mem_addr[7:0]);
    end

    // read-only memory for the latency-3 instance: three read stages
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= mem_addr3[7:0] ^ 32'h5A5A0000;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_out3 = p3[2];

    logic [31:0] ref_mem [256];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic single(input vec_t v);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        if (v.is_d) begin
            d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk("stall_pending", v.is_d ? stall_mem : stall_fetch, 1);
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) begin
                chk("grant_addr", mem_addr, v.addr);
                chk("grant_we", mem_write, v.is_d & v.wr);
                if (v.is_d) chk("grant_wdata", mem_in, v.wdata);
                chk("busy", busy, 1);
            end
            if (n == 2) chk("we_one_cycle", mem_write, 0);
            got = v.is_d ? d_ack : if_ack;
        end
        chk("ack_edge", n, 3);
        chk("rdata", v.is_d ? d_rdata : if_rdata, v.exp);
        chk("stall_at_ack", v.is_d ? stall_mem : stall_fetch, 0);
        if_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        if (v.is_d && v.wr) ref_mem[v.addr[7:0]] = v.wdata;
        tick();
        chk("ack_pulse", v.is_d ? d_ack : if_ack, 0);
        chk("idle", busy, 0);
    endtask

    // transaction-level reference for the random phase
    int          m_who;
    int          m_done;
    int          m_starve;
    logic [17:0] m_addr;
    bit          m_wr;
    logic        e_iack, e_dack, e_mw, e_busy;
    logic [31:0] e_irdata, e_drdata, e_min;
    logic [17:0] e_maddr;

    task automatic model_step();
        int  k;
        int  cw;
        bit  io, dok, pd, pi;
        k = edge_cnt + 1;
        e_iack = 0; e_dack = 0; e_mw = 0;
        cw = 0;
        pd = 0; pi = 0;
        if (m_who != 0 && k == m_done) begin
            cw = m_who;
            if (m_who == 1) begin
                e_iack = 1; e_irdata = ref_mem[m_addr[7:0]];
            end else begin
                e_dack = 1;
                if (!m_wr) e_drdata = ref_mem[m_addr[7:0]];
            end
            m_who = 0;
        end
        if (m_who == 0) begin
            io = if_req && cw != 1;
            dok = d_req && cw != 2;
            pd = dok && !(io && m_starve == LIM);
            pi = io && !pd;
            if (pd) begin
                m_who = 2; m_addr = d_addr; m_wr = d_write; m_done = k + L + 1;
                e_maddr = d_addr; e_min = d_wdata; e_mw = d_write;
                if (d_write) ref_mem[d_addr[7:0]] = d_wdata;
            end else if (pi) begin
                m_who = 1; m_addr = if_addr; m_wr = 0; m_done = k + L + 1;
                e_maddr = if_addr;
            end
        end
        if (!if_req || pi) m_starve = 0;
        else if (pd && m_starve < LIM) m_starve++;
        e_busy = (m_who != 0);
    endtask

    initial begin
        vec_t tbl[7];
        int n, di, ii, bz;
        bit got;

        tbl[0] = '{0, 0, 18'h10, 32'h0, 32'h2402000A};
        tbl[1] = '{1, 0, 18'h40, 32'h0, 32'h0000CAFE};
        tbl[2] = '{1, 1, 18'h08, 32'h1234, 32'h0000CAFE};
        tbl[3] = '{1, 0, 18'h08, 32'h0, 32'h1234};
        tbl[4] = '{0, 0, 18'h08, 32'h0, 32'h1234};
        tbl[5] = '{1, 1, 18'h40, 32'hBEEF, 32'h1234};
        tbl[6] = '{0, 0, 18'h40, 32'h0, 32'hBEEF};

        for (int i = 0; i < 256; i++) ref_mem[i] = base(8'(i));

        rst_signal = 1'b0;
        if_req = 0; d_req = 0; d_write = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req3 = 0; d_req3 = 0; d_write3 = 0; if_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
        tick();
        tick();
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_acks", {if_ack, d_ack}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_signal = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) single(tbl[i]);

        // simultaneous requests: D first, then I granted on D's completion edge
        if_req = 1; if_addr = 18'h20; d_req = 1; d_write = 0; d_addr = 18'h40;
        n = 0; di = 0; ii = 0;
        while ((di == 0 || ii == 0) && n < 20) begin
            tick();
            n++;
            if (n == 3) chk("t2_regrant_addr", mem_addr, 18'h20);
            if (d_ack) begin
                di = n; chk("t2_drdata", d_rdata, ref_mem[8'h40]); d_req = 0;
            end
            if (if_ack) begin
                ii = n; chk("t2_irdata", if_rdata, ref_mem[8'h20]); if_req = 0;
            end
        end
        chk("t2_d_edge", di, 3);
        chk("t2_i_edge", ii, 5);
        tick();

        // reset in the middle of a store
        d_req = 1; d_write = 1; d_addr = 18'h30; d_wdata = 32'h77;
        tick();
        chk("t5_we_before", mem_write, 1);
        #2 rst_signal = 1'b0;
        #1;
        chk("t5_we_dropped", mem_write, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_in", mem_in, 0);
        chk("t5_rdata", {if_rdata, d_rdata}, 0);
        chk("t5_busy", busy, 0);
        d_req = 0; d_write = 0;
        tick();
        chk("t5_no_ack", d_ack, 0);
        @(negedge clk);
        rst_signal = 1'b1;
        tick();
        single('{0, 0, 18'h30, 32'h0, ref_mem[8'h30]});

        // latency-3 instance: ack four edges after grant, busy for four cycles
        d_req3 = 1; d_addr3 = 18'h12;
        n = 0; bz = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (busy3) bz++;
            got = d_ack3;
        end
        d_req3 = 0;
        chk("t6_ack_edge", n, 5);
        chk("t6_busy_cycles", bz, 4);
        chk("t6_rdata", d_rdata3, 32'h5A5A0012);
        tick();
        chk("t6_idle", busy3, 0);

        // random traffic
        m_who = 0; m_done = 0; m_starve = 0; m_addr = 0; m_wr = 0;
        e_irdata = ref_mem[8'h30]; e_drdata = 0; e_min = 0; e_maddr = 18'h30;
        for (int c = 0; c < 800; c++) begin
            model_step();
            tick();
            chk("r_if_ack", if_ack, e_iack);
            chk("r_d_ack", d_ack, e_dack);
            chk("r_if_rdata", if_rdata, e_irdata);
            chk("r_d_rdata", d_rdata, e_drdata);
            chk("r_mem_write", mem_write, e_mw);
            chk("r_mem_addr", mem_addr, e_maddr);
            chk("r_mem_in", mem_in, e_min);
            chk("r_busy", busy, e_busy);
            chk("r_stalls", {stall_fetch, stall_mem}, {if_req & ~e_iack, d_req & ~e_dack});
            if (e_iack) if_req = 0;
            if (e_dack) d_req = 0;
            if (!if_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    if_req = 1; if_addr = 18'($urandom_range(255, 0));
                end
            end else if ($urandom_range(3, 0) == 0) begin
                if_addr = 18'($urandom_range(255, 0));
            end
            if (!d_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    d_req = 1; d_addr = 18'($urandom_range(255, 0));
                    d_write = 1'($urandom_range(1, 0)); d_wdata = $urandom;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                d_addr = 18'($urandom_range(255, 0));
                d_write = 1'($urandom_range(1, 0)); d_wdata = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
